// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    // Data bits carried by one 8N1 frame
    localparam int FRAME_BITS = 8;

    // Default clk cycles per serial bit
    localparam int CLKS_PER_BIT_DEF = 104;

    // Receiver frame states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_deser_sync2.sv
// Two-flop synchronizer that brings the asynchronous serial line into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running. Both flops reset to 1, which is the idle line level.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: deserializes rx and writes each good byte to a downstream FIFO.
// Latency: wwe rises the cycle after the mid-stop-bit sample (about 9.5 bit times after the start edge).
// Backpressure: fifo_full at the stop sample drops the byte and sets the sticky overrun flag.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       fifo_full,
    input  logic       clr_err,
    output logic [7:0] dout,
    output logic       wwe,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    // The counter only ever reaches CLKS_PER_BIT-1, so ceil(log2) bits never wrap.
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(FRAME_BITS - 1);

    logic            rx_s;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM with registered outputs; error sets are written after the clear so a
    // simultaneous set and clear resolves as set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dout      <= '0;
            wwe       <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wwe <= 1'b0;
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        if (!rx_s) begin
                            // Start bit confirmed at its centre; data samples follow a full bit later.
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            // Line returned high: treat as a glitch, silently.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        // LSB arrives first, so shifting in at the MSB leaves bit 0 at [0] after 8 samples.
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        // Back to IDLE on the sample edge so a start bit right after the stop bit's
                        // centre is not missed.
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (fifo_full) begin
                            // A write to a full FIFO would overwrite its tail, so drop the byte.
                            overrun <= 1'b1;
                        end else begin
                            dout <= shreg;
                            wwe  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
